// File: rtl/iter_shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shift_unit_if
//  Description : Request/response channel bundle for iter_shift_unit.
//                Request: in_valid/in_ready with A, B, MOD.
//                Response: out_valid/out_ready with C, plus busy status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iter_shift_unit_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic [2:0]      MOD;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] C;
  logic            busy;

  // Issue logic side: drives requests, consumes results
  modport master (
    output in_valid, A, B, MOD, out_ready,
    input  in_ready, out_valid, C, busy
  );

  // Shift unit side: accepts requests, produces results
  modport slave (
    input  in_valid, A, B, MOD, out_ready,
    output in_ready, out_valid, C, busy
  );
endinterface
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shift_unit
//  Description : Multi-cycle shift/LUI responder. Shifts at most STEP bits per
//                cycle. MOD: 000 SLLI, 001 SRLI, 010 SRAI, 011 SLL, 100 SRL,
//                101 SRA, 110 LUI, 111 -> result 0.
//  Options     : ITER_SHIFT_BACK2BACK_EN - accept a new op on the same edge
//                the previous result is consumed (no idle bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_shift_unit #(
  parameter int SIZE = 32,
  parameter int STEP = 4
) (
  input  wire                clk,
  input  wire                rst,
  iter_shift_unit_if.slave   bus
);

  localparam int              LW     = $clog2(SIZE);
  localparam logic [LW:0]     c_STEP = (LW+1)'(STEP);

  localparam logic [2:0] c_SLLI = 3'b000;
  localparam logic [2:0] c_SRLI = 3'b001;
  localparam logic [2:0] c_SRAI = 3'b010;
  localparam logic [2:0] c_SLL  = 3'b011;
  localparam logic [2:0] c_SRL  = 3'b100;
  localparam logic [2:0] c_SRA  = 3'b101;
  localparam logic [2:0] c_LUI  = 3'b110;
  localparam logic [2:0] c_ZERO = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   acc_q,   acc_d;
  logic [LW-1:0]     cnt_q,   cnt_d;
  logic [2:0]        op_q,    op_d;
  logic              sign_q,  sign_d;
  logic [SIZE-1:0]   c_q,     c_d;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_resp_done;
  logic [LW:0]       w_cnt_ext;
  logic [LW:0]       w_step_amt;
  logic [SIZE-1:0]   w_shl;
  logic [SIZE-1:0]   w_shr;
  logic [SIZE-1:0]   w_fill;
  logic [SIZE-1:0]   w_shifted;
  logic [LW-1:0]     w_cnt_next;
  logic [LW-1:0]     w_load_amt;
  logic [SIZE-1:0]   w_lui;

  // Request acceptance: idle always, optionally also while a result is drained
`ifdef ITER_SHIFT_BACK2BACK_EN
  assign w_in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
`else
  assign w_in_ready = (state_q == S_IDLE);
`endif

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_resp_done = (state_q == S_DONE) && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign bus.C         = c_q;

  assign w_load_amt = bus.B[LW-1:0];
  assign w_lui      = {bus.B[SIZE-13:0], 12'b0};

  // Per-cycle step: the remaining count, capped at STEP
  assign w_cnt_ext  = {1'b0, cnt_q};
  assign w_step_amt = (w_cnt_ext < c_STEP) ? w_cnt_ext : c_STEP;
  assign w_cnt_next = cnt_q - w_step_amt[LW-1:0];

  // One shift step; arithmetic right fills with the sign captured at accept
  always_comb begin
    w_shl     = acc_q << w_step_amt;
    w_shr     = acc_q >> w_step_amt;
    w_fill    = ~({SIZE{1'b1}} >> w_step_amt);
    w_shifted = w_shr;
    case (op_q)
      c_SLLI, c_SLL: w_shifted = w_shl;
      c_SRAI, c_SRA: w_shifted = sign_q ? (w_shr | w_fill) : w_shr;
      c_SRLI, c_SRL: w_shifted = w_shr;
      default:       w_shifted = w_shr;
    endcase
  end

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    c_d     = c_q;

    case (state_q)
      S_IDLE: begin
        // handled by the common load block below
      end
      S_SHIFT: begin
        acc_d = w_shifted;
        cnt_d = w_cnt_next;
        if (w_cnt_next == '0) begin
          c_d     = w_shifted;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (w_resp_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept edge; in back-to-back builds this can coincide with a response
    // handshake, in which case the new op takes precedence over returning idle.
    if (w_accept) begin
      op_d   = bus.MOD;
      acc_d  = bus.A;
      cnt_d  = w_load_amt;
      sign_d = bus.A[SIZE-1];
      if (bus.MOD == c_LUI) begin
        c_d     = w_lui;
        state_d = S_DONE;
      end else if (bus.MOD == c_ZERO) begin
        c_d     = '0;
        state_d = S_DONE;
      end else if (w_load_amt == '0) begin
        c_d     = bus.A;
        state_d = S_DONE;
      end else begin
        state_d = S_SHIFT;
      end
    end
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_shift_unit
//  Description : Directed self-checking bench for iter_shift_unit
//                (SIZE=32, STEP=4). Honours ITER_SHIFT_BACK2BACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shift_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  iter_shift_unit_if #(.SIZE(32)) bus ();

  iter_shift_unit #(.SIZE(32), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble request inputs while it runs, then wait for the
  // result and check latency and value. Leaves the result unconsumed.
  task automatic run_op(input string tag, input logic [2:0] mod, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.MOD      = mod;
    bus.A        = a;
    bus.B        = b;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 32'h5A5A_A5A5;
    bus.B        = 32'h0000_001F;
    bus.MOD      = 3'b011;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".C"}, bus.C, exp_c);
  endtask

  // Consume the pending result and confirm the unit returns idle
  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] c_hold;
    logic        seen;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.MOD       = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.C", bus.C, 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Shifts with out_ready already high
    bus.out_ready = 1'b1;
    run_op("sll31", 3'b011, 32'h0000_0001, 32'd31, 32'h8000_0000, 9);
    consume("sll31");
    run_op("sra4", 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 2);
    consume("sra4");
    run_op("srl4", 3'b100, 32'h8000_0000, 32'd4, 32'h0800_0000, 2);
    consume("srl4");
    run_op("lui", 3'b110, 32'hFFFF_FFFF, 32'h0001_2345, 32'h1234_5000, 1);
    consume("lui");
    run_op("slli0", 3'b000, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1);
    consume("slli0");
    run_op("mod7", 3'b111, 32'hDEAD_BEEF, 32'd5, 32'h0000_0000, 1);
    consume("mod7");
    run_op("srai31", 3'b010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9);
    consume("srai31");
    run_op("srli31", 3'b001, 32'h8000_0000, 32'd31, 32'h0000_0001, 9);
    consume("srli31");
    run_op("sll5", 3'b011, 32'h0000_0003, 32'd5, 32'h0000_0060, 3);
    consume("sll5");
    run_op("sra8pos", 3'b101, 32'h7000_0000, 32'd8, 32'h0070_0000, 3);
    consume("sra8pos");

    // Result stall: hold out_ready low for 5 cycles in DONE
    bus.out_ready = 1'b0;
    run_op("stall", 3'b100, 32'h0000_00F0, 32'd4, 32'h0000_000F, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.MOD      = 3'b110;
        bus.B        = 32'h0000_0001;
      end else begin
        bus.in_valid = 1'b0;
      end
      check("stall.out_valid", 32'(bus.out_valid), 32'd1);
      check("stall.C", bus.C, 32'h0000_000F);
      check("stall.in_ready", 32'(bus.in_ready), 32'd0);
      check("stall.busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    consume("stall");
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    check("stall.no_extra_resp", 32'(seen), 32'd0);
    check("stall.C_kept", bus.C, 32'h0000_000F);

    // Reset in the middle of a shift aborts the op
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.MOD      = 3'b100;
    bus.A        = 32'hFFFF_FFFF;
    bus.B        = 32'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.C", bus.C, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    check("abort.never_valid", 32'(seen), 32'd0);
    bus.out_ready = 1'b1;
    run_op("after_abort", 3'b100, 32'hFF00_0000, 32'd8, 32'h00FF_0000, 3);
    consume("after_abort");

    // Two LUI ops with in_valid and out_ready held high
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.MOD      = 3'b110;
    bus.B        = 32'h0000_0001;
    @(negedge clk);
    check("b2b.first_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.first_C", bus.C, 32'h0000_1000);
    bus.B = 32'h0000_0002;
`ifdef ITER_SHIFT_BACK2BACK_EN
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b.second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.second_C", bus.C, 32'h0000_2000);
`else
    @(negedge clk);
    check("b2b.gap", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b.second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.second_C", bus.C, 32'h0000_2000);
`endif
    consume("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
